// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry EX->MEM skid buffer with registered upstream stall, flush kill and bubble counter.
// Optional macro FLUSH_ID_EN: flush keeps entries whose fetchID matches i_flush_id.
module ex_mem_skid #(
  parameter int DW = 269,
  parameter int FID_LSB = 0,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   i_data,
  input  logic            i_v,
  output logic            o_stall_up,
  output logic [DW-1:0]   o_data,
  output logic            o_v,
  input  logic            i_stall_dn,
  input  logic            i_flush,
  input  logic [3:0]      i_flush_id,
  output logic [CNTW-1:0] o_bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, MAIN, FULL} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] m_q, m_d, s_q, s_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic acc, con;
`ifdef FLUSH_ID_EN
  logic m_ok, s_ok;
`else
  logic unused_fid;
  assign unused_fid = ^i_flush_id;
`endif
  assign o_v = state_q != EMPTY;
  assign o_stall_up = state_q == FULL;
  assign o_data = m_q;
  assign o_bubble_cnt = cnt_q;
  always_comb begin
    acc = i_v & ~o_stall_up & ~i_flush;
    con = o_v & ~i_stall_dn;
    state_d = state_q;
    m_d = m_q;
    s_d = s_q;
    cnt_d = (!o_v && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`ifdef FLUSH_ID_EN
    m_ok = o_v & ~con & (m_q[FID_LSB+:4] == i_flush_id);
    s_ok = o_stall_up & (s_q[FID_LSB+:4] == i_flush_id);
`endif
    if (i_flush) begin
`ifdef FLUSH_ID_EN
      state_d = (m_ok && s_ok) ? FULL : (m_ok || s_ok) ? MAIN : EMPTY;
      m_d = (!m_ok && s_ok) ? s_q : m_q;
`else
      state_d = EMPTY;
`endif
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          state_d = MAIN;
          m_d = i_data;
        end
        MAIN: if (acc && con) m_d = i_data;
        else if (acc) begin
          state_d = FULL;
          s_d = i_data;
        end else if (con) state_d = EMPTY;
        FULL: if (con) begin
          state_d = MAIN;
          m_d = s_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    m_q <= m_d;
    s_q <= s_d;
  end
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: randomized and directed checks of ex_mem_skid against a depth-2 FIFO reference model.
module tb_ex_mem_skid;
  logic clk = 0, rst = 1;
  logic [268:0] i_data = '0, o_data;
  logic i_v = 0, o_stall_up, o_v, i_stall_dn = 0, i_flush = 0;
  logic [3:0] i_flush_id = 0;
  logic [15:0] o_bubble_cnt;
  logic [268:0] q[$];
  int cnt, vec, err, consumed;

  ex_mem_skid dut (.clk(clk), .rst(rst), .i_data(i_data), .i_v(i_v), .o_stall_up(o_stall_up),
    .o_data(o_data), .o_v(o_v), .i_stall_dn(i_stall_dn), .i_flush(i_flush),
    .i_flush_id(i_flush_id), .o_bubble_cnt(o_bubble_cnt));

  always #5 clk = ~clk;

  function automatic logic [268:0] rnd(input logic [3:0] fid);
    logic [268:0] d = '0;
    for (int i = 0; i < 9; i++) d = {d[236:0], 32'($urandom)};
    d[3:0] = fid;
    return d;
  endfunction

  // Reference: a FIFO of at most two bundles; upstream is stalled exactly when it holds two.
  task automatic tick(output bit acc_o);
    bit acc, con;
    int n;
    logic [268:0] t[$];
    n = q.size();
    acc = i_v && n < 2 && !i_flush;
    con = n > 0 && !i_stall_dn;
    if (n == 0 && cnt < 65535) cnt++;
    @(posedge clk);
    #1;
    if (con) begin
      void'(q.pop_front());
      consumed++;
    end
    if (i_flush) begin
`ifdef FLUSH_ID_EN
      foreach (q[i]) if (q[i][3:0] == i_flush_id) t.push_back(q[i]);
      q = t;
`else
      q.delete();
`endif
    end else if (acc) q.push_back(i_data);
    acc_o = acc;
  endtask

  task automatic do_reset();
    rst = 1; i_v = 0; i_stall_dn = 0; i_flush = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (o_v !== 0 || o_stall_up !== 0 || o_bubble_cnt !== 0) begin
      err++;
      $display("FAIL reset: v=%b stall=%b cnt=%0d, want 0 0 0", o_v, o_stall_up, o_bubble_cnt);
    end
  endtask

  task automatic test_single();
    bit a;
    logic [268:0] a1 = rnd(4'h1);
    do_reset();
    i_v = 1; i_data = a1; i_stall_dn = 0;
    tick(a);
    i_v = 0;
    vec++;
    if (o_v !== 1 || o_data !== a1 || o_stall_up !== 0) begin
      err++;
      $display("FAIL single: v=%b stall=%b data=%h, want v=1 stall=0 data=%h", o_v, o_stall_up, o_data[31:0], a1[31:0]);
    end
    tick(a);
    vec++;
    if (o_v !== 0 || o_stall_up !== 0 || o_bubble_cnt !== 16'(cnt)) begin
      err++;
      $display("FAIL single_drain: v=%b stall=%b cnt=%0d, want 0 0 %0d", o_v, o_stall_up, o_bubble_cnt, cnt);
    end
  endtask

  task automatic test_skid();
    bit a;
    logic [268:0] b = rnd(4'h2), c = rnd(4'h3);
    do_reset();
    i_v = 1; i_data = b;
    tick(a);
    i_stall_dn = 1; i_data = c;
    tick(a);
    i_data = rnd(4'h4);
    vec++;
    if (o_v !== 1 || o_stall_up !== 1 || o_data !== b) begin
      err++;
      $display("FAIL skid_full: v=%b stall=%b data=%h, want 1 1 %h", o_v, o_stall_up, o_data[31:0], b[31:0]);
    end
    i_stall_dn = 0;
    tick(a);
    i_v = 0;
    vec++;
    if (o_v !== 1 || o_stall_up !== 0 || o_data !== c) begin
      err++;
      $display("FAIL skid_release: v=%b stall=%b data=%h, want 1 0 %h", o_v, o_stall_up, o_data[31:0], c[31:0]);
    end
    tick(a);
    vec++;
    if (o_v !== 0 || o_stall_up !== 0) begin
      err++;
      $display("FAIL skid_empty: v=%b stall=%b, want 0 0", o_v, o_stall_up);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int k = 0, cyc = 0;
    do_reset();
    consumed = 0;
    i_v = 1; i_data = rnd(4'(k));
    while (consumed < 100 && cyc < 1000) begin
      tick(a);
      cyc++;
      if (a) begin
        k++;
        i_v = k < 100;
        i_data = rnd(4'(k));
      end
      vec++;
      if (o_v !== (q.size() != 0) || o_stall_up !== (q.size() == 2) || (q.size() != 0 && o_data !== q[0])) begin
        err++;
        $display("FAIL stream cyc %0d: v=%b stall=%b data=%h, want v=%0d stall=%0d", cyc, o_v, o_stall_up, o_data[31:0], q.size() != 0, q.size() == 2);
      end
      i_stall_dn = ~i_stall_dn;
      #1;
      vec++;
      if (o_stall_up !== (q.size() == 2)) begin
        err++;
        $display("FAIL stall_comb cyc %0d: stall=%b want %0d", cyc, o_stall_up, q.size() == 2);
      end
    end
    vec++;
    if (consumed != 100 || k != 100) begin
      err++;
      $display("FAIL stream_count: consumed=%0d sent=%0d, want 100 100", consumed, k);
    end
    i_stall_dn = 0;
  endtask

  task automatic test_flush();
    bit a;
    do_reset();
    i_v = 1; i_data = rnd(4'h1);
    tick(a);
    i_stall_dn = 1; i_data = rnd(4'h2);
    tick(a);
    i_flush = 1; i_data = rnd(4'h3);
`ifdef FLUSH_ID_EN
    i_flush_id = 4'h9;
`endif
    tick(a);
    i_flush = 0; i_v = 0; i_stall_dn = 0;
    vec++;
    if (o_v !== 0 || o_stall_up !== 0) begin
      err++;
      $display("FAIL flush_full: v=%b stall=%b, want 0 0", o_v, o_stall_up);
    end
    tick(a);
    vec++;
    if (o_v !== 0 || o_bubble_cnt !== 16'(cnt)) begin
      err++;
      $display("FAIL flush_drop: v=%b cnt=%0d, want 0 %0d", o_v, o_bubble_cnt, cnt);
    end
  endtask

`ifdef FLUSH_ID_EN
  task automatic test_flush_id();
    bit a;
    logic [268:0] s = rnd(4'h5);
    do_reset();
    i_v = 1; i_stall_dn = 1; i_data = rnd(4'h3);
    tick(a);
    i_data = s;
    tick(a);
    i_flush = 1; i_flush_id = 4'h5; i_data = rnd(4'h5);
    tick(a);
    i_flush = 0; i_v = 0;
    vec++;
    if (o_v !== 1 || o_stall_up !== 0 || o_data !== s) begin
      err++;
      $display("FAIL flush_id: v=%b stall=%b data=%h, want 1 0 %h", o_v, o_stall_up, o_data[31:0], s[31:0]);
    end
    i_stall_dn = 0;
  endtask
`endif

  task automatic test_random();
    bit a;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_v = $urandom_range(3) != 0;
      i_stall_dn = $urandom_range(2) == 0;
      i_flush = $urandom_range(15) == 0;
      i_flush_id = 4'($urandom_range(3));
      i_data = rnd(4'($urandom_range(3)));
      tick(a);
      vec++;
      if (o_v !== (q.size() != 0) || o_stall_up !== (q.size() == 2) || o_bubble_cnt !== 16'(cnt) || (q.size() != 0 && o_data !== q[0])) begin
        err++;
        $display("FAIL rand cyc %0d: v=%b stall=%b cnt=%0d data=%h, want v=%0d stall=%0d cnt=%0d", c, o_v, o_stall_up, o_bubble_cnt, o_data[31:0], q.size() != 0, q.size() == 2, cnt);
      end
    end
    i_v = 0; i_flush = 0; i_stall_dn = 0;
  endtask

  task automatic test_bubble();
    bit a;
    do_reset();
    for (int c = 0; c < 70000; c++) begin
      tick(a);
      if (c == 65534) begin
        vec++;
        if (o_bubble_cnt !== 16'hFFFF) begin
          err++;
          $display("FAIL bubble_reach: cnt=%h want ffff", o_bubble_cnt);
        end
      end
    end
    vec++;
    if (o_bubble_cnt !== 16'hFFFF || cnt != 65535) begin
      err++;
      $display("FAIL bubble_sat: cnt=%h want ffff", o_bubble_cnt);
    end
    #2 rst = 1;
    #1;
    vec++;
    if (o_bubble_cnt !== 0 || o_v !== 0) begin
      err++;
      $display("FAIL async_rst: cnt=%h v=%b want 0 0", o_bubble_cnt, o_v);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_back_to_back();
    test_flush();
`ifdef FLUSH_ID_EN
    test_flush_id();
`endif
    test_random();
    test_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
